// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared types and helpers for the reg_pipe retiming slice.
package reg_pipe_pkg;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Per-stage controls; independent of WIDTH so any instance can share it.
    typedef struct packed {
        logic ld;
        logic clr;
    } stage_ctl_t;

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one valid+data register with async reset, load enable and flush clear.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  stage_ctl_t       ctl,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // Data only moves with a valid beat, so bubbles leave the old contents in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (ctl.clr) begin
            v <= 1'b0;
        end else if (ctl.ld) begin
            v <= v_in;
            if (v_in) d <= d_in;
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid/ready register pipeline with bubble collapsing and flush.
// Define REG_PIPE_OCC_EN to add the registered occupancy output.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0] occupancy
`endif
);

    if (DEPTH < 1) begin : g_depth_chk
        $error("reg_pipe: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d [DEPTH];
    stage_ctl_t       ctl [DEPTH];

    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_stage
        // A stage can move unless it and every stage after it are full and the sink stalls.
        assign rdy[i] = out_ready | ~&v[DEPTH-1:i];
        assign ctl[i] = '{ld: rdy[i], clr: flush};
        if (i == 0) begin : g_head
            reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk (clk),
                .rst (rst),
                .ctl (ctl[i]),
                .v_in(in_valid),
                .d_in(in_data),
                .v   (v[i]),
                .d   (d[i])
            );
        end else begin : g_body
            reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk (clk),
                .rst (rst),
                .ctl (ctl[i]),
                .v_in(v[i-1]),
                .d_in(d[i-1]),
                .v   (v[i]),
                .d   (d[i])
            );
        end
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_data  = d[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
    localparam int OW = occ_w(DEPTH);

    logic push;
    logic pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OW'(push) - OW'(pop);
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed and random checks of reg_pipe (WIDTH=8, DEPTH=3) with a scoreboard monitor.
module tb_reg_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
`ifdef REG_PIPE_OCC_EN
    logic [1:0] occupancy;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q [$];

    reg_pipe #(.WIDTH(8), .DEPTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef REG_PIPE_OCC_EN
        ,
        .occupancy(occupancy)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_occ(input string name, input int exp);
`ifdef REG_PIPE_OCC_EN
        chk(name, int'(occupancy), exp);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) step();
        chk("drain_left", exp_q.size(), 0);
        step();
    endtask

    // Scoreboard: accepted beats are queued; every output transfer must match the oldest.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
`ifdef REG_PIPE_OCC_EN
            chk("occ_vs_model", int'(occupancy), exp_q.size());
`endif
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_out: got 0x%0h, expected no transfer at %0t", out_data, $time);
                end else begin
                    chk("out_order", int'(out_data), int'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (flush) exp_q.delete();
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk_occ("rst_occ", 0);

        // Latency DEPTH, one beat per cycle
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        step();
        in_data = 8'h22;
        step();
        in_data = 8'h33;
        chk("lat_not_yet", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("lat_v0", out_valid, 1);
        chk("lat_d0", out_data, 8'h11);
        chk_occ("lat_occ3", 3);
        step();
        chk("lat_d1", out_data, 8'h22);
        step();
        chk("lat_d2", out_data, 8'h33);
        step();
        chk("lat_empty", out_valid, 0);
        chk_occ("lat_occ0", 0);
        drain();

        // Backpressure: fill, stall, then pop and push in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'hA0 + 8'(k);
            step();
        end
        in_data = 8'hA3;
        chk("full_in_ready", in_ready, 0);
        step();
        chk("full_hold_ready", in_ready, 0);
        chk("full_hold_data", out_data, 8'hA0);
        out_ready = 1'b1;
        #1;
        chk("full_pass_ready", in_ready, 1);
        step();
        drain();

        // Bubble collapse
        in_valid = 1'b1;
        in_data  = 8'h55;
        step();
        in_valid = 1'b0;
        step();
        step();
        in_valid  = 1'b1;
        in_data   = 8'h66;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        chk("bub_in_ready", in_ready, 1);
        chk("bub_out_data", out_data, 8'h55);
        chk_occ("bub_occ", 2);
        step();
        chk("bub_stable", out_data, 8'h55);
        drain();

        // Flush when full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'hB0 + 8'(k);
            step();
        end
        in_data = 8'hBF;
        flush   = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        chk("fl_out_valid", out_valid, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_after_valid", out_valid, 0);
        chk("fl_after_ready", in_ready, 1);
        chk("fl_data_kept", out_data, 8'hB0);
        chk_occ("fl_after_occ", 0);
        drain();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hC0;
        step();
        in_data = 8'hC1;
        step();
        in_valid = 1'b0;
        step();
        chk("ar_pre_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_data", out_data, 0);
        chk_occ("ar_occ", 0);
        step();
        rst = 1'b0;
        #1;
        chk("ar_rel_valid", out_valid, 0);
        chk("ar_rel_ready", in_ready, 1);
        step();
        chk("ar_no_pulse", out_valid, 0);

        // Random traffic against the scoreboard
        for (int n = 0; n < 10000; n++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = 8'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 63) == 0;
            step();
        end
        flush = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
